debounce_multi: RTL and testbench

- Parametrised successor to the calculator's fixed five-button / eight-switch debouncer.
- N_BTN button channels and N_SW switch channels.
- Each button channel provides:
  - a debounced level;
  - one-clock press and release pulses;
  - a long-press pulse;
  - an optional auto-repeat pulse train.
- Switch channels give debounced levels plus a one-clock change pulse.
- Sits between the board I/O pins and the calculator control FSM.
- Sampling rate is set by a tick-enable input, so the block can run on the 100 Hz clk_db or on a fast clock with a divided tick.

---
 rtl/debounce_pkg.sv | 42 ++++
 rtl/debounce_chan.sv | 160 ++++++++++++++++
 rtl/debounce_multi.sv | 82 ++++++++
 tb/tb_debounce_multi.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared constants, hold-FSM state type and counter sizing
//               helpers for the multi-channel button/switch debouncer.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package debounce_pkg;

  // Default parameter values for the calculator board
  localparam int DEF_N_BTN        = 5;
  localparam int DEF_N_SW         = 8;
  localparam int DEF_SAMPLES      = 3;
  localparam int DEF_LONG_TICKS   = 100;
  localparam int DEF_REPEAT_TICKS = 20;

  // Per-button hold tracking: idle, pressed-but-short, past the long threshold
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_e;

  // Hold counter must be able to hold the larger of the two compare values
  function automatic int hold_cnt_width(input int long_ticks, input int repeat_ticks);
    int m;
    m = long_ticks;
    if (repeat_ticks > m) m = repeat_ticks;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

  // Filter counter only ever stores 0..SAMPLES-1 (it clears at the compare)
  function automatic int filt_cnt_width(input int samples);
    int w;
    w = $clog2(samples);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One debounced channel: 2-FF synchroniser, agree-count filter
//               with hysteresis, edge pulses and an optional hold FSM that
//               produces long-press and auto-repeat pulses.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SAMPLES      = DEF_SAMPLES,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter bit HOLD_EN      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o,
  output logic rpt_o
);

  localparam int FW = filt_cnt_width(SAMPLES);
  localparam int HW = hold_cnt_width(LONG_TICKS, REPEAT_TICKS);

  // Compare values are "one before the target" because the event fires on
  // the edge where the counter would reach the target, never storing it.
  localparam logic [FW-1:0] FILT_LAST = FW'(SAMPLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'((LONG_TICKS   > 0) ? LONG_TICKS   - 1 : 0);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;

  hold_state_e   state_q;
  logic [HW-1:0] hcnt_q;
  logic          long_q;
  logic          rpt_q;

  // Two-flop synchroniser, runs every clock regardless of the sample strobe
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Filter next state: count consecutive disagreeing samples, toggle at SAMPLES
  always_comb begin
    level_d = level_q;
    fcnt_d  = fcnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (sync2_q != level_q) begin
        if (fcnt_q == FILT_LAST) begin
          level_d = ~level_q;
          fcnt_d  = '0;
          rise_d  = ~level_q;
          fall_d  = level_q;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end else begin
        fcnt_d = '0;
      end
    end
  end

  // Filter state and single-cycle edge pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
      fcnt_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Hold FSM: a release always wins, so no long/repeat pulse on the release edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      rpt_q  <= 1'b0;
      if (!HOLD_EN || fall_d) begin
        state_q <= IDLE;
        hcnt_q  <= '0;
      end else if (rise_d) begin
        state_q <= HELD;
        hcnt_q  <= '0;
      end else if (tick_i) begin
        case (state_q)
          IDLE: begin
            hcnt_q <= '0;
          end
          HELD: begin
            // LONG_TICKS of zero parks the channel here without counting
            if (LONG_TICKS != 0) begin
              if (hcnt_q == LONG_LAST) begin
                long_q  <= 1'b1;
                hcnt_q  <= '0;
                state_q <= LONG;
              end else begin
                hcnt_q <= hcnt_q + HW'(1);
              end
            end
          end
          LONG: begin
            if (REPEAT_TICKS != 0) begin
              if (hcnt_q == REP_LAST) begin
                rpt_q  <= 1'b1;
                hcnt_q <= '0;
              end else begin
                hcnt_q <= hcnt_q + HW'(1);
              end
            end
          end
          default: begin
            state_q <= IDLE;
            hcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign long_o  = long_q;
  assign rpt_o   = rpt_q;

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : N_BTN push-button and N_SW switch debouncer between board pins
//               and the calculator control FSM. Sampling pace is set by
//               tick_en; synchronisers always run at the clock rate.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_BTN        = DEF_N_BTN,
  parameter int N_SW         = DEF_N_SW,
  parameter int SAMPLES      = DEF_SAMPLES,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic             clk_db,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_rpt,
  output logic [N_SW-1:0]  sw_out,
  output logic             sw_chg
);

  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic [N_SW-1:0] sw_long;
  logic [N_SW-1:0] sw_rpt;

  // Button channels carry the hold FSM
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_chan #(
      .SAMPLES      (SAMPLES),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .HOLD_EN      (1'b1)
    ) u_chan (
      .clk_i   (clk_db),
      .rst_ni  (rst_n),
      .tick_i  (tick_en),
      .raw_i   (btn_in[i]),
      .level_o (btn_level[i]),
      .rise_o  (btn_press[i]),
      .fall_o  (btn_release[i]),
      .long_o  (btn_long[i]),
      .rpt_o   (btn_rpt[i])
    );
  end

  // Switch channels are plain level filters
  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_chan #(
      .SAMPLES      (SAMPLES),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .HOLD_EN      (1'b0)
    ) u_chan (
      .clk_i   (clk_db),
      .rst_ni  (rst_n),
      .tick_i  (tick_en),
      .raw_i   (sw_in[j]),
      .level_o (sw_out[j]),
      .rise_o  (sw_rise[j]),
      .fall_o  (sw_fall[j]),
      .long_o  (sw_long[j]),
      .rpt_o   (sw_rpt[j])
    );
  end

  // Any switch toggle raises the shared change pulse. Hold pulses are held
  // at zero on switch channels; OR-ing them in keeps every output consumed.
  assign sw_chg = |(sw_rise | sw_fall | sw_long | sw_rpt);

endmodule : debounce_multi
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_multi
// Description : Directed scenarios followed by random stimulus, every cycle
//               compared against a tick-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

  localparam int NB  = 5;
  localparam int NS  = 8;
  localparam int SMP = 3;
  localparam int LT  = 10;
  localparam int RT  = 4;

  logic          clk_db;
  logic          rst_n;
  logic          tick_en;
  logic [NB-1:0] btn_in;
  logic [NS-1:0] sw_in;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long, btn_rpt;
  logic [NS-1:0] sw_out;
  logic          sw_chg;

  int vectors    = 0;
  int miscompares = 0;

  debounce_multi #(
    .N_BTN(NB), .N_SW(NS), .SAMPLES(SMP), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
  ) dut (
    .clk_db      (clk_db),
    .rst_n       (rst_n),
    .tick_en     (tick_en),
    .btn_in      (btn_in),
    .sw_in       (sw_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_rpt     (btn_rpt),
    .sw_out      (sw_out),
    .sw_chg      (sw_chg)
  );

  initial begin
    clk_db = 1'b0;
    forever #5 clk_db = ~clk_db;
  end

  // ---------------- reference model ----------------
  logic [NB-1:0] m_bs1, m_bs2, m_blev, m_press, m_rel, m_long, m_rpt;
  logic [NS-1:0] m_ss1, m_ss2, m_slev;
  logic          m_chg;
  int            b_run  [NB];
  int            s_run  [NS];
  int            held_t [NB];

  task automatic model_edge(input logic r, input logic t,
                            input logic [NB-1:0] b, input logic [NS-1:0] s);
    if (!r) begin
      m_bs1 = '0; m_bs2 = '0; m_blev = '0;
      m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
      m_ss1 = '0; m_ss2 = '0; m_slev = '0; m_chg = 1'b0;
      for (int i = 0; i < NB; i++) begin b_run[i] = 0; held_t[i] = 0; end
      for (int i = 0; i < NS; i++) s_run[i] = 0;
    end else begin
      m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0; m_chg = 1'b0;
      if (t) begin
        for (int i = 0; i < NB; i++) begin
          bit tog;
          tog = 1'b0;
          if (m_bs2[i] != m_blev[i]) begin
            b_run[i]++;
            if (b_run[i] == SMP) begin
              b_run[i]  = 0;
              m_blev[i] = ~m_blev[i];
              tog = 1'b1;
              if (m_blev[i]) begin m_press[i] = 1'b1; held_t[i] = 0; end
              else m_rel[i] = 1'b1;
            end
          end else begin
            b_run[i] = 0;
          end
          // Ticks elapsed since the press decide long and repeat directly
          if (!tog && m_blev[i]) begin
            held_t[i]++;
            if (held_t[i] == LT) m_long[i] = 1'b1;
            else if (held_t[i] > LT && ((held_t[i] - LT) % RT) == 0) m_rpt[i] = 1'b1;
          end
        end
        for (int i = 0; i < NS; i++) begin
          if (m_ss2[i] != m_slev[i]) begin
            s_run[i]++;
            if (s_run[i] == SMP) begin
              s_run[i]  = 0;
              m_slev[i] = ~m_slev[i];
              m_chg     = 1'b1;
            end
          end else begin
            s_run[i] = 0;
          end
        end
      end
      m_bs2 = m_bs1; m_bs1 = b;
      m_ss2 = m_ss1; m_ss1 = s;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance model with pre-edge inputs, then compare outputs
  task automatic step();
    @(posedge clk_db);
    model_edge(rst_n, tick_en, btn_in, sw_in);
    #1;
    chk("btn_level",   btn_level,   m_blev);
    chk("btn_press",   btn_press,   m_press);
    chk("btn_release", btn_release, m_rel);
    chk("btn_long",    btn_long,    m_long);
    chk("btn_rpt",     btn_rpt,     m_rpt);
    chk("sw_out",      sw_out,      m_slev);
    chk("sw_chg",      sw_chg,      m_chg);
  endtask

  initial begin
    int first, cnt, others, p, l, r1, r2, rel, rpt_after, w;
    int pat [8];
    pat = '{1, 1, 0, 1, 1, 0, 0, 0};

    rst_n = 1'b0; tick_en = 1'b1; btn_in = '0; sw_in = '0;
    repeat (3) step();
    chk("rst_btn_level", btn_level, 0);
    chk("rst_sw_out", sw_out, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // S1: clean press on button 0
    btn_in[0] = 1'b1; first = -1; cnt = 0; others = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (btn_press[0]) begin cnt++; if (first < 0) first = k; end
      if (btn_press[NB-1:1] != '0 || btn_release != '0) others++;
    end
    chk("s1_press_edge", first, 5);
    chk("s1_press_count", cnt, 1);
    chk("s1_other_chan", others, 0);
    chk("s1_level", btn_level[0], 1);
    btn_in[0] = 1'b0;
    repeat (8) step();

    // S2: bounce on button 1 never qualifies
    cnt = 0; others = 0;
    for (int k = 0; k < 16; k++) begin
      btn_in[1] = (k < 8) ? pat[k][0] : 1'b0;
      step();
      if (btn_press[1] || btn_release[1]) cnt++;
      if (btn_level[1]) others++;
    end
    chk("s2_pulses", cnt, 0);
    chk("s2_level", others, 0);

    // S3: long hold on button 2 with repeats, then release
    btn_in[2] = 1'b1; p = -1; l = -1; r1 = -1; r2 = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (btn_press[2] && p < 0) p = k;
      if (btn_long[2] && l < 0) l = k;
      if (btn_rpt[2]) begin if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k; end
    end
    chk("s3_press_edge", p, 5);
    chk("s3_long_delay", l - p, LT);
    chk("s3_rpt1_delay", r1 - l, RT);
    chk("s3_rpt2_delay", r2 - l, 2 * RT);
    btn_in[2] = 1'b0; rel = -1; cnt = 0; rpt_after = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (btn_release[2]) begin cnt++; if (rel < 0) rel = k; end
      if (rel >= 0 && btn_rpt[2]) rpt_after++;
      if (rel >= 0 && btn_long[2]) rpt_after++;
    end
    chk("s3_release_edge", rel, 5);
    chk("s3_release_count", cnt, 1);
    chk("s3_rpt_after_rel", rpt_after, 0);

    // S4: sample strobe every 4th clock
    btn_in[0] = 1'b1; first = -1; w = 0;
    for (int k = 1; k <= 16; k++) begin
      tick_en = ((k % 4) == 0);
      step();
      if (btn_press[0]) begin w++; if (first < 0) first = k; end
    end
    chk("s4_press_edge", first, 12);
    chk("s4_pulse_width", w, 1);
    tick_en = 1'b1;
    btn_in[0] = 1'b0;
    repeat (8) step();

    // S5: simultaneous switch change, then a one-edge glitch
    sw_in = 8'hA5; first = -1; cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (sw_out == 8'hA5 && first < 0) first = k;
      if (sw_chg) cnt++;
    end
    chk("s5_sw_edge", first, 5);
    chk("s5_chg_count", cnt, 1);
    cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      sw_in = (k == 1) ? 8'h25 : 8'hA5;
      step();
      if (sw_chg) cnt++;
    end
    chk("s5_glitch_chg", cnt, 0);
    chk("s5_glitch_out", sw_out, 8'hA5);

    // S6: reset while button 3 is in its long/repeat phase
    btn_in[3] = 1'b1;
    repeat (20) step();
    rst_n = 1'b0;
    step();
    chk("s6_rst_level", btn_level, 0);
    chk("s6_rst_sw", sw_out, 0);
    chk("s6_rst_pulses", {btn_press, btn_release, btn_long, btn_rpt, 7'd0, sw_chg}, 0);
    step();
    rst_n = 1'b1; p = -1; l = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_press[3] && p < 0) p = k;
      if (btn_long[3] && l < 0) l = k;
    end
    chk("s6_repress_edge", p, 5);
    chk("s6_relong_edge", l, 5 + LT);
    btn_in[3] = 1'b0;
    repeat (8) step();

    // Random phase against the model
    for (int k = 0; k < 1500; k++) begin
      int bi, si;
      bi = $urandom_range(0, NB - 1);
      si = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 15) == 0) btn_in[bi] = ~btn_in[bi];
      if ($urandom_range(0, 15) == 0) sw_in[si] = ~sw_in[si];
      tick_en = ($urandom_range(0, 3) != 0);
      rst_n   = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_debounce_multi
`default_nettype wire
